// File: rtl/pnode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pnode_pkg
// Description : Shared widths, types and CSR map for the pnode tagger and
//               anything that decodes its beats.
// Revision    : 1.0 - initial release
// ============================================================================
package pnode_pkg;

    localparam int TAG_W   = 12;
    localparam int DATA_W  = 128;
    localparam int PNODE_W = TAG_W + 2 + DATA_W;

    typedef logic [TAG_W-1:0] tag_t;

    // Layout of one emitted beat; tag occupies the MSBs
    typedef struct packed {
        tag_t              tag;
        logic              sop;
        logic              eop;
        logic [DATA_W-1:0] data;
    } pnode_beat_t;

    // Packet framing state
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } pkt_state_e;

    // CSR word addresses
    localparam logic [1:0] CSR_NEXT_TAG = 2'd0;
    localparam logic [1:0] CSR_PKT_CNT  = 2'd1;
    localparam logic [1:0] CSR_DROP_CNT = 2'd2;
    localparam logic [1:0] CSR_ERR_CNT  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/pnode_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : pnode_skid_buffer
// Description : Two-entry valid/ready buffer. The input ready is a registered
//               "not full" flag, so it never depends combinationally on the
//               downstream ready. Head entry drives the output directly.
// Revision    : 1.0 - initial release
// ============================================================================
module pnode_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             ready_q;
    logic             w_push;
    logic             w_pop;

    assign w_push      = in_valid_i & ready_q;
    assign w_pop       = (count_q != 2'd0) & out_ready_i;
    assign in_ready_o  = ready_q;
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = head_q;

    // Next-state of the two slots: head is always the oldest beat
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = in_data_i;
                end else begin
                    tail_d = in_data_i;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                if (count_q == 2'd2) begin
                    head_d = tail_q;
                end
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Push while full cannot happen: ready_q is low at count 2
                if (count_q == 2'd1) begin
                    head_d = in_data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = in_data_i;
                end
            end
            default: ;
        endcase
    end

    // Slot registers and registered not-full flag
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
            ready_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ready_q <= (count_d != 2'd2);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pnode_tagger_128.sv
`default_nettype none
// ============================================================================
// Module      : pnode_tagger_128
// Description : Tags every beat of an upstream packet stream with a per-packet
//               tag, drops beats that arrive outside a packet, and exposes
//               next-tag / packet / drop / error counters on a small CSR port.
// Revision    : 1.0 - initial release
// ============================================================================
module pnode_tagger_128 #(
    parameter int TAG_W  = pnode_pkg::TAG_W,
    parameter int DATA_W = pnode_pkg::DATA_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [DATA_W-1:0]         asi_data,
    input  logic                      asi_sop,
    input  logic                      asi_eop,
    input  logic                      asi_valid,
    output logic                      asi_ready,
    output logic [TAG_W+2+DATA_W-1:0] pnode_data,
    output logic                      pnode_valid,
    input  logic                      pnode_ready,
    input  logic                      avs_cfg_write,
    input  logic                      avs_cfg_read,
    input  logic [1:0]                avs_cfg_address,
    input  logic [31:0]               avs_cfg_writedata,
    output logic [31:0]               avs_cfg_readdata
);

    import pnode_pkg::*;

    localparam int               BEAT_W  = TAG_W + 2 + DATA_W;
    localparam logic [TAG_W-1:0] TAG_ONE = {{(TAG_W-1){1'b0}}, 1'b1};

    pkt_state_e        state_q, state_d;
    logic [TAG_W-1:0]  next_tag_q, next_tag_d;
    logic [TAG_W-1:0]  cur_tag_q, cur_tag_d;
    logic [31:0]       pkt_cnt_q, pkt_cnt_d;
    logic [31:0]       drop_cnt_q, drop_cnt_d;
    logic [31:0]       err_cnt_q, err_cnt_d;
    logic [31:0]       rdata_q;

    logic              w_rst;
    logic              w_accept;
    logic              w_keep;
    logic              w_drop;
    logic              w_err;
    logic [TAG_W-1:0]  w_beat_tag;
    logic [TAG_W-1:0]  w_wr_tag;
    logic [BEAT_W-1:0] w_beat;
    logic              w_unused_wdata;

    assign w_rst    = ~reset;
    assign w_accept = asi_valid & asi_ready;
    assign w_beat   = {w_beat_tag, asi_sop, asi_eop, asi_data};
    // Tag 0 is reserved, so a CSR write of 0 is promoted to 1
    assign w_wr_tag = (avs_cfg_writedata[TAG_W-1:0] == '0) ? TAG_ONE
                                                            : avs_cfg_writedata[TAG_W-1:0];
    assign w_unused_wdata = ^avs_cfg_writedata[31:TAG_W];

    // Framing FSM and tag assignment for the beat being accepted this cycle
    always_comb begin
        state_d    = state_q;
        next_tag_d = next_tag_q;
        cur_tag_d  = cur_tag_q;
        w_beat_tag = cur_tag_q;
        w_keep     = 1'b0;
        w_drop     = 1'b0;
        w_err      = 1'b0;
        if (w_accept) begin
            if (asi_sop) begin
                // Any sop opens a new packet, even one arriving mid-packet
                w_keep     = 1'b1;
                w_beat_tag = next_tag_q;
                cur_tag_d  = next_tag_q;
                next_tag_d = (next_tag_q == {TAG_W{1'b1}}) ? TAG_ONE : next_tag_q + TAG_ONE;
                w_err      = (state_q == ST_IN_PKT);
                state_d    = asi_eop ? ST_IDLE : ST_IN_PKT;
            end else if (state_q == ST_IDLE) begin
                w_drop = 1'b1;
            end else begin
                w_keep = 1'b1;
                if (asi_eop) begin
                    state_d = ST_IDLE;
                end
            end
        end
        // A CSR write wins over the advance; the sop above already used the old value
        if (avs_cfg_write && (avs_cfg_address == CSR_NEXT_TAG)) begin
            next_tag_d = w_wr_tag;
        end
    end

    // Event counters; a CSR write clears and overrides a same-cycle increment
    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (w_accept && asi_eop) begin
            pkt_cnt_d = pkt_cnt_q + 32'd1;
        end
        if (w_drop && (drop_cnt_q != 32'hFFFF_FFFF)) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
        end
        if (w_err && (err_cnt_q != 32'hFFFF_FFFF)) begin
            err_cnt_d = err_cnt_q + 32'd1;
        end
        if (avs_cfg_write) begin
            case (avs_cfg_address)
                CSR_PKT_CNT:  pkt_cnt_d  = '0;
                CSR_DROP_CNT: drop_cnt_d = '0;
                CSR_ERR_CNT:  err_cnt_d  = '0;
                default: ;
            endcase
        end
    end

    // State, tag and counter registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            next_tag_q <= TAG_ONE;
            cur_tag_q  <= '0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            next_tag_q <= next_tag_d;
            cur_tag_q  <= cur_tag_d;
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // CSR read data: captured one cycle after a read, held otherwise
    always_ff @(posedge clock) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if (avs_cfg_read) begin
            case (avs_cfg_address)
                CSR_NEXT_TAG: rdata_q <= 32'(next_tag_q);
                CSR_PKT_CNT:  rdata_q <= pkt_cnt_q;
                CSR_DROP_CNT: rdata_q <= drop_cnt_q;
                default:      rdata_q <= err_cnt_q;
            endcase
        end
    end

    assign avs_cfg_readdata = rdata_q;

    pnode_skid_buffer #(
        .WIDTH (BEAT_W)
    ) u_skid (
        .clk         (clock),
        .rst         (w_rst),
        .in_data_i   (w_beat),
        .in_valid_i  (w_keep),
        .in_ready_o  (asi_ready),
        .out_data_o  (pnode_data),
        .out_valid_o (pnode_valid),
        .out_ready_i (pnode_ready)
    );

endmodule
`default_nettype wire

// File: tb/tb_pnode_tagger_128.sv
`default_nettype none
// ============================================================================
// Module      : tb_pnode_tagger_128
// Description : Self-checking bench for pnode_tagger_128: directed tables and
//               sequences plus randomized traffic against a packet-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pnode_tagger_128;
    import pnode_pkg::*;

    typedef struct {
        logic sop;
        logic eop;
        logic keep;
        int   tag;
    } vec_t;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic [DATA_W-1:0]  asi_data = '0;
    logic               asi_sop = 1'b0, asi_eop = 1'b0, asi_valid = 1'b0;
    logic               asi_ready;
    logic [PNODE_W-1:0] pnode_data;
    logic               pnode_valid;
    logic               pnode_ready = 1'b1;
    logic               avs_cfg_write = 1'b0, avs_cfg_read = 1'b0;
    logic [1:0]         avs_cfg_address = '0;
    logic [31:0]        avs_cfg_writedata = '0;
    logic [31:0]        avs_cfg_readdata;

    int n_tests = 0;
    int n_fail  = 0;
    bit toggle_rdy = 0;

    // Reference model state
    int                 m_next_tag = 1;
    int                 m_cur_tag  = 0;
    bit                 m_in_pkt   = 0;
    logic [31:0]        m_pkt = 0, m_drop = 0, m_err = 0;
    logic [PNODE_W-1:0] exp_q[$];
    int                 sop_tags[$];

    pnode_tagger_128 dut (
        .clock             (clock),
        .reset             (reset),
        .asi_data          (asi_data),
        .asi_sop           (asi_sop),
        .asi_eop           (asi_eop),
        .asi_valid         (asi_valid),
        .asi_ready         (asi_ready),
        .pnode_data        (pnode_data),
        .pnode_valid       (pnode_valid),
        .pnode_ready       (pnode_ready),
        .avs_cfg_write     (avs_cfg_write),
        .avs_cfg_read      (avs_cfg_read),
        .avs_cfg_address   (avs_cfg_address),
        .avs_cfg_writedata (avs_cfg_writedata),
        .avs_cfg_readdata  (avs_cfg_readdata)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [PNODE_W-1:0] act, input logic [PNODE_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Packet-level rules: sop opens a packet with a fresh non-zero tag,
    // beats outside a packet vanish, a sop inside a packet is an error.
    task automatic model_accept(input logic s, input logic e, input logic [DATA_W-1:0] d);
        int maxt;
        maxt = (1 << TAG_W) - 1;
        if (e) m_pkt = m_pkt + 1;
        if (s) begin
            if (m_in_pkt && m_err != 32'hFFFF_FFFF) m_err = m_err + 1;
            m_cur_tag  = m_next_tag;
            m_next_tag = (m_next_tag % maxt) + 1;
            m_in_pkt   = !e;
            exp_q.push_back({tag_t'(m_cur_tag), s, e, d});
        end else if (!m_in_pkt) begin
            if (m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 1;
        end else begin
            exp_q.push_back({tag_t'(m_cur_tag), s, e, d});
            if (e) m_in_pkt = 0;
        end
    endtask

    task automatic model_write(input logic [1:0] a, input logic [31:0] wd);
        int t;
        case (a)
            2'd0: begin
                t = int'(wd) & ((1 << TAG_W) - 1);
                m_next_tag = (t == 0) ? 1 : t;
            end
            2'd1: m_pkt  = 0;
            2'd2: m_drop = 0;
            default: m_err = 0;
        endcase
    endtask

    function automatic logic [31:0] model_csr(input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_next_tag);
            2'd1:    return m_pkt;
            2'd2:    return m_drop;
            default: return m_err;
        endcase
    endfunction

    task automatic model_reset();
        m_next_tag = 1; m_cur_tag = 0; m_in_pkt = 0;
        m_pkt = 0; m_drop = 0; m_err = 0;
        exp_q.delete();
        sop_tags.delete();
    endtask

    // One clock: account for transfers at the coming edge, then check after it
    task automatic tick();
        bit                 stalled, rd;
        logic [PNODE_W-1:0] held, e;
        logic [31:0]        rdv;
        pnode_beat_t        ob;
        stalled = pnode_valid && !pnode_ready;
        held    = pnode_data;
        rd      = 0;
        rdv     = '0;
        if (!reset) begin
            model_reset();
        end else begin
            if (pnode_valid && pnode_ready) begin
                ob = pnode_beat_t'(pnode_data);
                if (ob.sop) sop_tags.push_back(int'(ob.tag));
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL extra beat: got %0h, want no beat", pnode_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out beat", pnode_data, e);
                end
            end
            if (avs_cfg_read) begin
                rd  = 1;
                rdv = model_csr(avs_cfg_address);
            end
            if (asi_valid && asi_ready) model_accept(asi_sop, asi_eop, asi_data);
            if (avs_cfg_write) model_write(avs_cfg_address, avs_cfg_writedata);
        end
        @(posedge clock);
        #1;
        if (reset) begin
            chk("pnode_valid", pnode_valid, exp_q.size() != 0);
            chk("asi_ready", asi_ready, exp_q.size() < 2);
            if (stalled) chk("stall hold", pnode_data, held);
            if (rd) chk("csr readdata", avs_cfg_readdata, rdv);
        end
    endtask

    task automatic reset_dut();
        asi_valid = 0; avs_cfg_read = 0; avs_cfg_write = 0; pnode_ready = 1;
        reset = 0;
        tick();
        chk("rst asi_ready", asi_ready, 0);
        chk("rst pnode_valid", pnode_valid, 0);
        chk("rst pnode_data", pnode_data, 0);
        chk("rst readdata", avs_cfg_readdata, 0);
        reset = 1;
        tick();
        chk("asi_ready after reset", asi_ready, 1);
    endtask

    task automatic send_beat(input logic s, input logic e, input logic [DATA_W-1:0] d);
        bit done;
        done = 0;
        asi_valid = 1; asi_sop = s; asi_eop = e; asi_data = d;
        for (int k = 0; k < 16 && !done; k++) begin
            if (toggle_rdy) pnode_ready = !pnode_ready;
            done = asi_ready;
            tick();
        end
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL accept timeout: got asi_ready=0 for 16 cycles, want accept");
        end
    endtask

    task automatic send_pkt(input int n, input logic [DATA_W-1:0] d);
        for (int i = 0; i < n; i++) send_beat(i == 0, i == n - 1, d);
        asi_valid = 0;
    endtask

    task automatic drain();
        asi_valid = 0; pnode_ready = 1; avs_cfg_read = 0; avs_cfg_write = 0;
        for (int i = 0; i < 8 && exp_q.size() != 0; i++) tick();
        chk("drain empty", exp_q.size() == 0, 1);
    endtask

    task automatic csr_read(input logic [1:0] a, input logic [31:0] exp, input string name);
        asi_valid = 0;
        avs_cfg_read = 1; avs_cfg_address = a;
        tick();
        avs_cfg_read = 0;
        chk(name, avs_cfg_readdata, exp);
    endtask

    task automatic csr_write(input logic [1:0] a, input logic [31:0] wd);
        asi_valid = 0;
        avs_cfg_write = 1; avs_cfg_address = a; avs_cfg_writedata = wd;
        tick();
        avs_cfg_write = 0;
    endtask

    task automatic chk_tags(input string name, input int n, input int t0, input int t1, input int t2, input int t3);
        int e[4];
        e[0] = t0; e[1] = t1; e[2] = t2; e[3] = t3;
        chk({name, " count"}, sop_tags.size(), n);
        for (int i = 0; i < n && i < sop_tags.size(); i++) chk(name, sop_tags[i], e[i]);
        sop_tags.delete();
    endtask

    initial begin
        vec_t              tbl[11];
        pnode_beat_t       ob;
        logic [DATA_W-1:0] allf, d55, dv;

        allf = '1;
        d55  = {(DATA_W/2){2'b01}};

        // drops, mid-packet sop, single-beat packet; tags from a fresh reset
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 2};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 2};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 2};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 3};

        // 8-beat all-ones packet: one-cycle latency, tag 1 on every beat
        reset_dut();
        chk("idle pnode_valid", pnode_valid, 0);
        for (int i = 0; i < 8; i++) begin
            send_beat(i == 0, i == 7, allf);
            ob = pnode_beat_t'(pnode_data);
            chk("p8 valid", pnode_valid, 1);
            chk("p8 tag", ob.tag, 1);
            chk("p8 sop", ob.sop, i == 0);
            chk("p8 eop", ob.eop, i == 7);
            chk("p8 data", ob.data, allf);
        end
        drain();

        // Table-driven framing cases
        reset_dut();
        for (int i = 0; i < 11; i++) begin
            dv = {4{32'hC0DE_0000 + 32'(i)}};
            send_beat(tbl[i].sop, tbl[i].eop, dv);
            chk("tbl valid", pnode_valid, tbl[i].keep);
            if (tbl[i].keep) begin
                ob = pnode_beat_t'(pnode_data);
                chk("tbl tag", ob.tag, tbl[i].tag);
                chk("tbl sop", ob.sop, tbl[i].sop);
                chk("tbl eop", ob.eop, tbl[i].eop);
                chk("tbl data", ob.data, dv);
            end
        end
        drain();
        csr_read(2'd2, 32'd3, "drop_cnt");
        csr_read(2'd3, 32'd1, "err_cnt");
        csr_read(2'd1, 32'd2, "pkt_cnt");
        csr_read(2'd0, 32'd4, "next_tag");
        tick();
        chk("readdata hold", avs_cfg_readdata, 4);

        // Clear and increment of pkt_cnt in the same cycle leaves 0
        send_beat(1'b1, 1'b0, d55);
        avs_cfg_write = 1; avs_cfg_address = 2'd1; avs_cfg_writedata = '0;
        send_beat(1'b0, 1'b1, d55);
        avs_cfg_write = 0;
        drain();
        csr_read(2'd1, 32'd0, "pkt clear wins");
        csr_write(2'd0, 32'd0);
        csr_read(2'd0, 32'd1, "next_tag write 0");

        // Back-to-back packets and tag wrap
        reset_dut();
        for (int p = 0; p < 4; p++) send_pkt(8, allf);
        drain();
        chk_tags("b2b tags", 4, 1, 2, 3, 4);
        csr_read(2'd1, 32'd4, "pkt_cnt b2b");
        csr_write(2'd0, 32'd4095);
        for (int p = 0; p < 4; p++) send_pkt(8, allf);
        drain();
        chk_tags("wrap tags", 4, 4095, 1, 2, 3);

        // next_tag write during an open packet applies only to the next one
        send_beat(1'b1, 1'b0, d55);
        csr_write(2'd0, 32'd100);
        send_beat(1'b0, 1'b1, d55);
        send_pkt(1, d55);
        drain();
        chk_tags("inflight write", 2, 4, 100, 0, 0);

        // Downstream ready toggling every cycle
        toggle_rdy = 1;
        send_pkt(8, d55);
        toggle_rdy = 0;
        drain();
        chk_tags("toggle tags", 1, 101, 0, 0, 0);

        // Reset in the middle of a packet
        send_beat(1'b1, 1'b0, d55);
        send_beat(1'b1, 1'b0, d55);
        send_beat(1'b0, 1'b0, d55);
        reset_dut();
        chk("mid rst pnode_valid", pnode_valid, 0);
        csr_read(2'd1, 32'd0, "mid rst pkt_cnt");
        csr_read(2'd2, 32'd0, "mid rst drop_cnt");
        csr_read(2'd3, 32'd0, "mid rst err_cnt");
        csr_read(2'd0, 32'd1, "mid rst next_tag");
        send_pkt(2, allf);
        drain();
        chk_tags("post rst tag", 1, 1, 0, 0, 0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            reset           = (($urandom % 700) != 0);
            asi_valid       = (($urandom % 4) != 0);
            asi_sop         = (($urandom % 4) == 0);
            asi_eop         = (($urandom % 4) == 0);
            asi_data        = {$urandom, $urandom, $urandom, $urandom};
            pnode_ready     = (($urandom % 3) != 0);
            avs_cfg_read    = (($urandom % 8) == 0);
            avs_cfg_write   = (($urandom % 64) == 0);
            avs_cfg_address = 2'($urandom % 4);
            avs_cfg_writedata = (($urandom % 2) != 0) ? 32'(4090 + ($urandom % 7)) : $urandom;
            tick();
        end
        reset = 1;
        drain();
        csr_read(2'd0, model_csr(2'd0), "rand next_tag");
        csr_read(2'd1, model_csr(2'd1), "rand pkt_cnt");
        csr_read(2'd2, model_csr(2'd2), "rand drop_cnt");
        csr_read(2'd3, model_csr(2'd3), "rand err_cnt");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
